// File: rtl/tail_light_pkg.sv
// Shared types and helpers for the sequential tail-light controller.
//   mode_t  : driver-control decode on CL (off / left / right / hazard)
//   phase_t : controller phase
//   side_t  : which side is signalling in the current sweep
package tail_light_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'b00,
        LEFT   = 2'b01,
        RIGHT  = 2'b10,
        HAZARD = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        HAZ_ON = 2'd2,
        DARK   = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        SIDE_LEFT  = 2'd0,
        SIDE_RIGHT = 2'd1,
        SIDE_HAZ   = 2'd2
    } side_t;

    // Counter width for a modulus, never below one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Step-rate prescaler: tick is high on the last cycle of every TICK_DIV-cycle step.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   clr   : restart the count (phase entry)
//   en    : count this cycle
//   tick  : cnt == TICK_DIV-1
module tick_prescaler
    import tail_light_pkg::*;
#(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = clog2_min1(TICK_DIV);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(TICK_DIV - 1));

    // Wraps on tick; clr has priority so every phase starts at cnt=0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/tail_light_seq.sv
// Sequential turn-signal / hazard tail-light controller with brake overlay.
//   clk        : system clock
//   reset      : asynchronous active-high reset
//   CL         : mode (00 off, 01 left, 10 right, 11 hazard), sampled in IDLE and at DARK tick
//   brake      : brake pedal level, registered before use
//   y          : lamps; y[2N-1:N] left (outer at MSB), y[N-1:0] right (outer at LSB)
//   active     : controller not idle
//   sweep_done : pulse on the last cycle of each DARK phase
module tail_light_seq
    import tail_light_pkg::*;
#(
    parameter int unsigned LAMPS_PER_SIDE = 3,
    parameter int unsigned TICK_DIV       = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [1:0]                  CL,
    input  logic                        brake,
    output logic [2*LAMPS_PER_SIDE-1:0] y,
    output logic                        active,
    output logic                        sweep_done
);

    localparam int unsigned N  = LAMPS_PER_SIDE;
    localparam int unsigned SW = clog2_min1(N);
    localparam logic [N-1:0] ALL_ON = '1;

    phase_t        phase, phase_n;
    side_t         side, side_n;
    logic [SW-1:0] step, step_n;
    logic          brake_q;
    logic          tick;
    logic          launch;
    logic          cnt_clr;
    logic          cnt_en;
    logic [N-1:0]  sweep_mask;
    logic [N-1:0]  sweep_rev;
    logic [N-1:0]  left_lamps;
    logic [N-1:0]  right_lamps;

    assign cnt_clr = (phase_n != phase);
    assign cnt_en  = (phase != IDLE);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tick  (tick)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase   <= IDLE;
            side    <= SIDE_LEFT;
            step    <= '0;
            brake_q <= 1'b0;
        end else begin
            phase   <= phase_n;
            side    <= side_n;
            step    <= step_n;
            brake_q <= brake;
        end
    end

    // Next-state: CL is only looked at in IDLE and on the DARK tick.
    always_comb begin
        phase_n = phase;
        side_n  = side;
        step_n  = step;
        launch  = 1'b0;
        case (phase)
            IDLE:   launch = 1'b1;
            SWEEP: begin
                if (tick) begin
                    if (step == SW'(N - 1)) phase_n = DARK;
                    else                    step_n  = step + SW'(1);
                end
            end
            HAZ_ON: if (tick) phase_n = DARK;
            DARK:   if (tick) launch = 1'b1;
            default: phase_n = IDLE;
        endcase
        if (launch) begin
            step_n = '0;
            case (mode_t'(CL))
                LEFT: begin
                    phase_n = SWEEP;
                    side_n  = SIDE_LEFT;
                end
                RIGHT: begin
                    phase_n = SWEEP;
                    side_n  = SIDE_RIGHT;
                end
                HAZARD: begin
                    phase_n = HAZ_ON;
                    side_n  = SIDE_HAZ;
                end
                OFF:     phase_n = IDLE;
                default: phase_n = IDLE;
            endcase
        end
    end

    // Lamps 0..step lit counting from the inner lamp; right side is mirrored.
    assign sweep_mask = ~(ALL_ON << (int'(step) + 1));
    assign sweep_rev  = {<<{sweep_mask}};

    // Output decode from registered state and brake_q only.
    always_comb begin
        left_lamps  = '0;
        right_lamps = '0;
        active      = (phase != IDLE);
        sweep_done  = (phase == DARK) && tick;
        case (phase)
            IDLE: begin
                left_lamps  = {N{brake_q}};
                right_lamps = {N{brake_q}};
            end
            SWEEP: begin
                if (side == SIDE_LEFT) begin
                    left_lamps  = sweep_mask;
                    right_lamps = {N{brake_q}};
                end else begin
                    left_lamps  = {N{brake_q}};
                    right_lamps = sweep_rev;
                end
            end
            HAZ_ON: begin
                left_lamps  = ALL_ON;
                right_lamps = ALL_ON;
            end
            DARK: begin
                // Hazard dark ignores brake; after a sweep the other side follows brake.
                if (side == SIDE_LEFT)       right_lamps = {N{brake_q}};
                else if (side == SIDE_RIGHT) left_lamps  = {N{brake_q}};
            end
            default: begin
                left_lamps  = '0;
                right_lamps = '0;
            end
        endcase
    end

    assign y = {left_lamps, right_lamps};

endmodule

// File: tb/tb_tail_light_seq.sv
// Scoreboard bench for tail_light_seq (N=3, TICK_DIV=4, 10-unit clock).
// Stimulus pushes the expected outputs of each cycle; the monitor pops and
// compares on the falling edge.
module tb_tail_light_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] CL;
    logic       brake;
    logic [5:0] y;
    logic       active;
    logic       sweep_done;

    typedef struct {
        logic [5:0] y;
        logic       a;
        logic       d;
        int         id;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_bad  = 0;
    int   id_cnt = 0;

    always #5 clk = ~clk;

    tail_light_seq #(
        .LAMPS_PER_SIDE (3),
        .TICK_DIV       (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .CL         (CL),
        .brake      (brake),
        .y          (y),
        .active     (active),
        .sweep_done (sweep_done)
    );

    // Expected outputs for the cycle that follows the next rising edge.
    task automatic expect_cyc(input logic [5:0] ey, input logic ea, input logic ed);
        exp_t e;
        @(posedge clk);
        #1;
        e.y  = ey;
        e.a  = ea;
        e.d  = ed;
        e.id = id_cnt;
        id_cnt++;
        sb.push_back(e);
    endtask

    // n identical cycles; sweep_done expectation applies to the last one only.
    task automatic seg(input logic [5:0] ey, input logic ea, input int n, input logic last_done);
        for (int i = 0; i < n; i++)
            expect_cyc(ey, ea, (i == n - 1) ? last_done : 1'b0);
    endtask

    // Monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                n_vec++;
                if ({y, active, sweep_done} !== {e.y, e.a, e.d}) begin
                    n_bad++;
                    $display("FAIL vec%0d t=%0t: got y=%b active=%b sweep_done=%b, want y=%b active=%b sweep_done=%b",
                             e.id, $time, y, active, sweep_done, e.y, e.a, e.d);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        reset = 1'b1;
        CL    = 2'b00;
        brake = 1'b0;

        // Reset state.
        seg(6'b000000, 1'b0, 4, 1'b0);
        #5;
        reset = 1'b0;
        CL    = 2'b01;

        // Left sweep, twice; CL changed to right during step 2 of the second.
        seg(6'b001000, 1'b1, 4, 1'b0);
        seg(6'b011000, 1'b1, 4, 1'b0);
        seg(6'b111000, 1'b1, 4, 1'b0);
        seg(6'b000000, 1'b1, 4, 1'b1);
        seg(6'b001000, 1'b1, 4, 1'b0);
        seg(6'b011000, 1'b1, 4, 1'b0);
        seg(6'b111000, 1'b1, 2, 1'b0);
        CL = 2'b10;
        seg(6'b111000, 1'b1, 2, 1'b0);
        seg(6'b000000, 1'b1, 4, 1'b1);

        // Right sweep, then hazard.
        seg(6'b000100, 1'b1, 4, 1'b0);
        seg(6'b000110, 1'b1, 4, 1'b0);
        seg(6'b000111, 1'b1, 4, 1'b0);
        CL = 2'b11;
        seg(6'b000000, 1'b1, 4, 1'b1);
        seg(6'b111111, 1'b1, 4, 1'b0);
        seg(6'b000000, 1'b1, 4, 1'b1);

        // Hazard with brake: no change.
        brake = 1'b1;
        seg(6'b111111, 1'b1, 1, 1'b0);
        CL = 2'b01;
        seg(6'b111111, 1'b1, 3, 1'b0);
        seg(6'b000000, 1'b1, 4, 1'b1);

        // Left sweep with brake overlay on the right side.
        seg(6'b001111, 1'b1, 4, 1'b0);
        seg(6'b011111, 1'b1, 4, 1'b0);
        seg(6'b111111, 1'b1, 4, 1'b0);
        CL = 2'b00;
        seg(6'b000111, 1'b1, 4, 1'b1);

        // Idle with brake: all on, brake follows with one cycle of delay.
        seg(6'b111111, 1'b0, 3, 1'b0);
        brake = 1'b0;
        seg(6'b000000, 1'b0, 2, 1'b0);
        brake = 1'b1;
        seg(6'b111111, 1'b0, 1, 1'b0);
        brake = 1'b0;
        CL    = 2'b01;
        seg(6'b001000, 1'b1, 2, 1'b0);

        // Asynchronous reset between edges.
        #6;
        reset = 1'b1;
        #1;
        n_vec++;
        if ({y, active, sweep_done} !== 8'b0) begin
            n_bad++;
            $display("FAIL async_reset t=%0t: got y=%b active=%b sweep_done=%b, want all zero",
                     $time, y, active, sweep_done);
        end
        CL = 2'b00;
        seg(6'b000000, 1'b0, 2, 1'b0);
        reset = 1'b0;
        seg(6'b000000, 1'b0, 3, 1'b0);

        // Drain scoreboard with a bounded wait.
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected vectors never compared, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Watchdog.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation exceeded time limit at t=%0t, want finish before 20000", $time);
        $fatal(1);
    end

endmodule

// File: doc/tail_light_seq.md
Name: tail_light_seq

Overview:
- Parametrised sequential turn-signal/hazard tail-light controller and the successor to the fixed 6-lamp FSM.
- Generalises to N lamps per side with a programmable step rate (clock prescale).
- Adds a brake overlay, sweep-completion handshake, and mode change only at sweep boundaries.
- Sits between the driver-control decode and the lamp drivers.

Parameters:
- LAMPS_PER_SIDE, 3: lamps per side (N); legal range 1..16.
- TICK_DIV, 4: clock cycles each sequence step is held; legal range 1..2^16.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  reset, asynchronous and active-high.
- CL  in  2  mode: 00 off, 01 left, 10 right, 11 hazard.
- brake  in  1  brake pedal, level.
- y  out  2*N  lamps. y[2N-1:N] is the left side, outer lamp at MSB, inner at y[N]. y[N-1:0] is the right side, inner at y[N-1], outer at y[0].
- active  out  1  high whenever state != IDLE.
- sweep_done  out  1  one-cycle pulse on the last cycle of each DARK phase.

Behaviour:
- Reset:
  - Asynchronous: while reset=1, state=IDLE, step=0, cnt=0, brake_q=0, y=0, active=0, sweep_done=0.
  - Reset asserted mid-sweep clears all outputs immediately, with no clock needed.
- Brake register: brake is registered to brake_q every cycle. y, active and sweep_done are combinational decodes of the state registers and brake_q only. No comb path exists from any input to any output.
- State registers:
  - phase: IDLE, SWEEP, HAZ_ON, DARK.
  - side: LEFT, RIGHT, HAZ.
  - step: 0..N-1.
  - cnt: 0..TICK_DIV-1.
  - tick = (cnt == TICK_DIV-1). cnt increments every cycle outside IDLE, wraps on tick, and is cleared on every phase entry.
- IDLE:
  - CL sampled every edge.
  - 01 -> SWEEP/LEFT, step=0. 10 -> SWEEP/RIGHT, step=0. 11 -> HAZ_ON/HAZ. 00 -> stay.
  - Latency from the sampling edge to the first lamp lit is 1 clock.
- SWEEP: on tick, if step < N-1 then step++, else -> DARK.
  - LEFT lights y[N+k] for k = 0..step.
  - RIGHT lights y[N-1-k] for k = 0..step.
  - Each step lasts exactly TICK_DIV cycles.
- HAZ_ON: all 2N lamps lit; on tick -> DARK.
- DARK: signalled lamps off for TICK_DIV cycles. sweep_done=1 on the tick cycle.
  - On tick, CL is re-sampled using the same decode as IDLE: a new sweep/hazard starts, or 00 -> IDLE.
- Mode change: CL is ignored in SWEEP and HAZ_ON, so a sweep in progress always completes through DARK. A change takes effect only at a DARK tick.
- Brake overlay when brake_q=1:
  - IDLE: all 2N lamps on.
  - SWEEP: the non-signalling side is fully on; the signalling side keeps sequencing.
  - DARK after a sweep: the non-signalling side stays on.
  - HAZ_ON/DARK after hazard: brake ignored.
- Edge cases:
  - TICK_DIV=1: tick every cycle, so each step lasts 1 cycle.
  - N=1: a sweep is a single step then DARK.

Decomposition:
- Package tail_light_pkg holds:
  - typedef enum mode_t {OFF=2'b00, LEFT=2'b01, RIGHT=2'b10, HAZARD=2'b11};
  - typedef enum phase_t {IDLE, SWEEP, HAZ_ON, DARK};
  - typedef enum side_t.
- Sub-module tick_prescaler (param TICK_DIV; ports clk, reset, clr, en, tick) owns cnt.

Test Plan (N=3, TICK_DIV=4, 10 ns clock):
- Left sweep: reset=1 to 41 ns, then CL=01, brake=0 -> y = 001000 x4 cycles, 011000 x4, 111000 x4, 000000 x4 with sweep_done on the 4th dark cycle; then the sweep repeats, and active=1 throughout.
- Right sweep: CL=10 -> y = 000100 x4, 000110 x4, 000111 x4, 000000 x4; repeats.
- Hazard: CL=11 -> y alternates 111111 x4 / 000000 x4. Set brake=1 -> no change.
- Mid-sweep mode change: CL switches 01->10 during left step 2 -> left completes 111000, then 000000 x4, then 000100. Then CL=00 at a DARK tick -> IDLE, y=000000, active=0.
- Brake overlay: CL=01, brake=1 -> y = 001111, 011111, 111111, 000111 (x4 each), delayed one cycle from brake. CL=00, brake=1 -> y=111111.
- Async reset: assert reset mid-sweep between edges -> y=0, active=0 in the same timestep. Release with CL=00 -> stays IDLE with y=000000.
